cpu_mem_bridge: RTL and testbench
=================================

Name: cpu_mem_bridge

Overview:
- Downstream of the multi-cycle RISC-V core; consumes both of its memory-side handshake channels.
- The instruction channel carries PC, Inst_Req_Valid/Ready, Instruction and Inst_Valid/Ready.
- The data channel carries Address, MemRead/MemWrite, Write_data/strb, Mem_Req_Ready, Read_data and Read_data_Valid/Ready.
- Serialises all requests onto one single-port synchronous SRAM with fixed read latency, and returns responses through valid/ready.
- Also exposes request counters for the core's perf-counter slots.

Parameters:
ADDR_W, 16, SRAM word-address width (byte address bits [ADDR_W+1:2] used)
RD_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid (legal range 1..7)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
PC  in  32  instruction byte address
Inst_Req_Valid  in  1  instruction request valid
Inst_Req_Ready  out  1  instruction request accepted
Instruction  out  32  fetched instruction word
Inst_Valid  out  1  Instruction valid
Inst_Ready  in  1  core accepts Instruction
Address  in  32  data byte address, word aligned
MemRead  in  1  data read request
MemWrite  in  1  data write request
Write_data  in  32  store data
Write_strb  in  4  byte enables, bit i = byte lane i
Mem_Req_Ready  out  1  data request accepted
Read_data  out  32  loaded word
Read_data_Valid  out  1  Read_data valid
Read_data_Ready  in  1  core accepts Read_data
mem_en  out  1  SRAM access enable
mem_wen  out  4  SRAM byte write enables (nonzero only with mem_en)
mem_addr  out  ADDR_W  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data
inst_cnt  out  32  accepted instruction requests
load_cnt  out  32  accepted data reads
store_cnt  out  32  accepted data writes

Behaviour:
- Reset: clk and rst as named above; reset is asynchronous, active-high.
  - Under reset, state goes to IDLE immediately and every output is 0, including all counters, Instruction and Read_data.
- States: IDLE, WR, ISSUE, WAIT, IRSP, DRSP.
- IDLE:
  - Mem_Req_Ready = 1 and Inst_Req_Ready = ~(MemRead|MemWrite); both are combinational in IDLE and 0 in every other state.
  - Priority is write > data read > instruction.
  - Accepting MemWrite latches addr/data/strb and goes to WR.
  - Accepting MemRead latches addr and goes to ISSUE with the data tag.
  - Accepting an instruction request latches PC and goes to ISSUE with the instruction tag.
  - MemRead and MemWrite together are treated as a write.
- WR: one cycle with mem_en=1, mem_wen=latched strb, mem_wdata=latched data, then IDLE.
  - Write_strb = 0 still completes the handshake; no byte changes.
- ISSUE: one cycle with mem_en=1, mem_wen=0, mem_addr=latched addr; then WAIT.
  - The WAIT counter is loaded with RD_LAT-1.
- WAIT: counts down each cycle.
  - When the counter is 0, mem_rdata is captured into the response register for the tagged channel, and the state moves to IRSP or DRSP.
  - With RD_LAT=1, WAIT lasts exactly one cycle.
- IRSP / DRSP:
  - IRSP holds Inst_Valid=1 and DRSP holds Read_data_Valid=1, with the data stable, until the matching Ready=1 at a rising edge.
  - Valid then drops and the state returns to IDLE.
- Latency: a read accepted in cycle T has Valid high in cycle T+2+RD_LAT. A write accepted in T writes the SRAM in T+1.
- Addressing:
  - mem_addr = latched byte address [ADDR_W+1:2].
  - Upper bits are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
  - Bits [1:0] are ignored.
- Counters increment on the accepting IDLE cycle and wrap from 0xFFFFFFFF to 0.
- Response registers keep their last value after Valid drops.
- Requests raised outside IDLE are not accepted; they wait, and Ready stays 0.
- Reset mid-transaction discards the in-flight access and response. The partially waited SRAM read has no effect.

Test Plan:
- Reset, then idle → all outputs 0, Inst_Req_Ready=1, Mem_Req_Ready=1.
- Preload word 0x00000013 at word 4; PC=0x10 with Inst_Req_Valid at T, Inst_Ready=1, RD_LAT=1 → mem_en=1 and mem_addr=4 at T+1; Inst_Valid=1 with Instruction=0x00000013 at T+3; inst_cnt=1.
- Write 0xAABBCCDD to Address=0x20 with Write_strb=4'b0100, over previous word 0x11223344; then read it back → SRAM word 8 = 0x11BB3344, Read_data=0x11BB3344, store_cnt=1, load_cnt=1.
- MemRead and Inst_Req_Valid raised in the same cycle → data access first with Inst_Req_Ready=0; instruction accepted in the first IDLE after DRSP completes.
- Hold Read_data_Ready=0 for 5 cycles during DRSP → Read_data_Valid stays 1 and the data is stable; a single transfer occurs when Ready rises; then IDLE.
- RD_LAT=3, Address=0x40000010, ADDR_W=16 → mem_addr=4 (wrap); Read_data_Valid at T+5. Asserting rst at T+3 drops all outputs to 0 asynchronously and no response is ever produced.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// Bridges the core's instruction and data handshake channels onto one single-port
// synchronous SRAM with fixed read latency, serialising every access.
module cpu_mem_bridge #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ready,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic [31:0]       Address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  output logic              Mem_Req_Ready,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       inst_cnt,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt
);

  typedef enum logic [2:0] {IDLE, WR, ISSUE, WAIT, IRSP, DRSP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_strb;
  logic              r_tag_data;
  logic [2:0]        r_wait;
  logic [31:0]       r_inst;
  logic [31:0]       r_rdata;
  logic [31:0]       r_inst_cnt;
  logic [31:0]       r_load_cnt;
  logic [31:0]       r_store_cnt;

  logic w_idle;
  logic w_acc_wr;
  logic w_acc_rd;
  logic w_acc_inst;
  logic w_unused;

  // Readies are gated by rst so that every output reads 0 while reset is held.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_acc_wr   = w_idle && MemWrite;
  assign w_acc_rd   = w_idle && !MemWrite && MemRead;
  assign w_acc_inst = w_idle && !MemWrite && !MemRead && Inst_Req_Valid;

  assign Mem_Req_Ready   = w_idle;
  assign Inst_Req_Ready  = w_idle && !(MemRead || MemWrite);
  assign Inst_Valid      = (r_state == IRSP);
  assign Read_data_Valid = (r_state == DRSP);
  assign Instruction     = r_inst;
  assign Read_data       = r_rdata;
  assign mem_en          = (r_state == WR) || (r_state == ISSUE);
  assign mem_wen         = (r_state == WR) ? r_strb : 4'b0000;
  assign mem_addr        = r_addr;
  assign mem_wdata       = r_wdata;
  assign inst_cnt        = r_inst_cnt;
  assign load_cnt        = r_load_cnt;
  assign store_cnt       = r_store_cnt;

  assign w_unused = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc_wr) begin
          w_state_next = WR;
        end else if (w_acc_rd || w_acc_inst) begin
          w_state_next = ISSUE;
        end
      end
      WR:    w_state_next = IDLE;
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (r_wait == 3'd0) begin
          w_state_next = r_tag_data ? DRSP : IRSP;
        end
      end
      IRSP: begin
        if (Inst_Ready) begin
          w_state_next = IDLE;
        end
      end
      DRSP: begin
        if (Read_data_Ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_tag_data  <= 1'b0;
      r_wait      <= '0;
      r_inst      <= '0;
      r_rdata     <= '0;
      r_inst_cnt  <= '0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else begin
      if (w_acc_wr) begin
        r_addr      <= Address[ADDR_W+1:2];
        r_wdata     <= Write_data;
        r_strb      <= Write_strb;
        r_store_cnt <= r_store_cnt + 32'd1;
      end else if (w_acc_rd) begin
        r_addr     <= Address[ADDR_W+1:2];
        r_tag_data <= 1'b1;
        r_load_cnt <= r_load_cnt + 32'd1;
      end else if (w_acc_inst) begin
        r_addr     <= PC[ADDR_W+1:2];
        r_tag_data <= 1'b0;
        r_inst_cnt <= r_inst_cnt + 32'd1;
      end

      // The countdown expires in the cycle the SRAM presents the read word.
      if (r_state == ISSUE) begin
        r_wait <= WAIT_INIT;
      end else if (r_state == WAIT) begin
        if (r_wait == 3'd0) begin
          if (r_tag_data) begin
            r_rdata <= mem_rdata;
          end else begin
            r_inst <= mem_rdata;
          end
        end else begin
          r_wait <= r_wait - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small behavioural SRAM with the matching read latency.
module tb_cpu_mem_bridge;

  logic clk;
  int   pass_cnt;
  int   total_cnt;

  // Instance with RD_LAT=1
  logic        rst1;
  logic [31:0] PC, Address, Write_data, Instruction, Read_data, mem_wdata, mem_rdata;
  logic [31:0] inst_cnt, load_cnt, store_cnt;
  logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
  logic        MemRead, MemWrite, Mem_Req_Ready, Read_data_Valid, Read_data_Ready, mem_en;
  logic [3:0]  Write_strb, mem_wen;
  logic [15:0] mem_addr;

  // Instance with RD_LAT=3
  logic        rst3;
  logic [31:0] PC_3, Address_3, Write_data_3, Instruction_3, Read_data_3, mem_wdata_3, mem_rdata_3;
  logic [31:0] inst_cnt_3, load_cnt_3, store_cnt_3;
  logic        Inst_Req_Valid_3, Inst_Req_Ready_3, Inst_Valid_3, Inst_Ready_3;
  logic        MemRead_3, MemWrite_3, Mem_Req_Ready_3, Read_data_Valid_3, Read_data_Ready_3, mem_en_3;
  logic [3:0]  Write_strb_3, mem_wen_3;
  logic [15:0] mem_addr_3;

  logic [31:0] sram1 [0:255];
  logic [31:0] sram3 [0:255];
  logic [31:0] rd3_a, rd3_b;

  cpu_mem_bridge #(.ADDR_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Address(Address),
    .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .inst_cnt(inst_cnt), .load_cnt(load_cnt),
    .store_cnt(store_cnt)
  );

  cpu_mem_bridge #(.ADDR_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .PC(PC_3), .Inst_Req_Valid(Inst_Req_Valid_3), .Inst_Req_Ready(Inst_Req_Ready_3),
    .Instruction(Instruction_3), .Inst_Valid(Inst_Valid_3), .Inst_Ready(Inst_Ready_3), .Address(Address_3),
    .MemRead(MemRead_3), .MemWrite(MemWrite_3), .Write_data(Write_data_3), .Write_strb(Write_strb_3),
    .Mem_Req_Ready(Mem_Req_Ready_3), .Read_data(Read_data_3), .Read_data_Valid(Read_data_Valid_3),
    .Read_data_Ready(Read_data_Ready_3), .mem_en(mem_en_3), .mem_wen(mem_wen_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .inst_cnt(inst_cnt_3), .load_cnt(load_cnt_3),
    .store_cnt(store_cnt_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: byte-masked writes, reads delayed by the instance's RD_LAT.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) sram1[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram1[mem_addr[7:0]];
      end
    end
  end

  always @(posedge clk) begin
    rd3_a       <= (mem_en_3 && mem_wen_3 == 4'b0000) ? sram3[mem_addr_3[7:0]] : rd3_a;
    rd3_b       <= rd3_a;
    mem_rdata_3 <= rd3_b;
    if (mem_en_3 && mem_wen_3 != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen_3[b]) sram3[mem_addr_3[7:0]][8*b +: 8] <= mem_wdata_3[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    total_cnt++;
    if ({Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid, mem_en, mem_wen, Instruction, Read_data,
         mem_addr, mem_wdata, inst_cnt, load_cnt, store_cnt} !== '0)
      $display("FAIL reset_outputs_dut1: some output nonzero under reset"); else pass_cnt++;
    total_cnt++;
    if ({Inst_Req_Ready_3, Mem_Req_Ready_3, Inst_Valid_3, Read_data_Valid_3, mem_en_3, Read_data_3, load_cnt_3} !== '0)
      $display("FAIL reset_outputs_dut3: some output nonzero under reset"); else pass_cnt++;
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    total_cnt++;
    if ({Inst_Req_Ready, Mem_Req_Ready} !== 2'b11)
      $display("FAIL idle_readies: got %b want 11", {Inst_Req_Ready, Mem_Req_Ready}); else pass_cnt++;
    total_cnt++;
    if ({Inst_Valid, Read_data_Valid, mem_en, inst_cnt, load_cnt, store_cnt} !== '0)
      $display("FAIL idle_outputs: valid/en/counters nonzero after reset"); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_inst_fetch();
    tick();
    PC = 32'h10; Inst_Req_Valid = 1'b1;
    #1;
    total_cnt++;
    if (Inst_Req_Ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", Inst_Req_Ready); else pass_cnt++;
    tick();
    Inst_Req_Valid = 1'b0;
    total_cnt++;
    if ({mem_en, mem_wen, mem_addr} !== {1'b1, 4'h0, 16'd4})
      $display("FAIL fetch_issue: got en=%b wen=%h addr=%0d want en=1 wen=0 addr=4", mem_en, mem_wen, mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (inst_cnt !== 32'd1) $display("FAIL fetch_inst_cnt: got %0d want 1", inst_cnt); else pass_cnt++;
    tick();
    total_cnt++;
    if (Inst_Valid !== 1'b0) $display("FAIL fetch_early_valid: got %b want 0", Inst_Valid); else pass_cnt++;
    tick();
    total_cnt++;
    if ({Inst_Valid, Instruction} !== {1'b1, 32'h00000013})
      $display("FAIL fetch_rsp: got valid=%b inst=%h want valid=1 inst=00000013", Inst_Valid, Instruction);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Inst_Valid, Inst_Req_Ready} !== 2'b01)
      $display("FAIL fetch_done: got valid=%b ready=%b want 0 1", Inst_Valid, Inst_Req_Ready); else pass_cnt++;
    $display("test_inst_fetch done");
  endtask

  task automatic test_write_read();
    MemWrite = 1'b1; Address = 32'h20; Write_data = 32'hAABBCCDD; Write_strb = 4'b0100;
    #1;
    total_cnt++;
    if ({Mem_Req_Ready, Inst_Req_Ready} !== 2'b10)
      $display("FAIL wr_readies: got %b want 10", {Mem_Req_Ready, Inst_Req_Ready}); else pass_cnt++;
    tick();
    MemWrite = 1'b0;
    total_cnt++;
    if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {1'b1, 4'b0100, 16'd8, 32'hAABBCCDD})
      $display("FAIL wr_sram_port: got en=%b wen=%b addr=%0d wdata=%h want 1 0100 8 aabbccdd",
               mem_en, mem_wen, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (store_cnt !== 32'd1) $display("FAIL wr_store_cnt: got %0d want 1", store_cnt); else pass_cnt++;
    tick();
    total_cnt++;
    if (sram1[8] !== 32'h11BB3344) $display("FAIL wr_merge: got %h want 11bb3344", sram1[8]); else pass_cnt++;
    MemRead = 1'b1; Address = 32'h20;
    tick();
    MemRead = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({Read_data_Valid, Read_data} !== {1'b1, 32'h11BB3344})
      $display("FAIL rd_back: got valid=%b data=%h want 1 11bb3344", Read_data_Valid, Read_data); else pass_cnt++;
    total_cnt++;
    if (load_cnt !== 32'd1) $display("FAIL rd_load_cnt: got %0d want 1", load_cnt); else pass_cnt++;
    tick();
    MemWrite = 1'b1; Address = 32'h14; Write_data = 32'hFFFFFFFF; Write_strb = 4'b0000;
    tick();
    MemWrite = 1'b0;
    total_cnt++;
    if ({mem_en, mem_wen, store_cnt} !== {1'b1, 4'h0, 32'd2})
      $display("FAIL wr_zero_strb: got en=%b wen=%h cnt=%0d want 1 0 2", mem_en, mem_wen, store_cnt); else pass_cnt++;
    tick();
    total_cnt++;
    if (sram1[5] !== 32'hDEADBEEF) $display("FAIL wr_zero_strb_data: got %h want deadbeef", sram1[5]); else pass_cnt++;
    $display("test_write_read done");
  endtask

  task automatic test_priority();
    MemRead = 1'b1; Address = 32'h20; Inst_Req_Valid = 1'b1; PC = 32'h10;
    #1;
    total_cnt++;
    if ({Mem_Req_Ready, Inst_Req_Ready} !== 2'b10)
      $display("FAIL prio_readies: got %b want 10", {Mem_Req_Ready, Inst_Req_Ready}); else pass_cnt++;
    tick();
    MemRead = 1'b0;
    total_cnt++;
    if ({load_cnt, inst_cnt, Inst_Req_Ready} !== {32'd2, 32'd1, 1'b0})
      $display("FAIL prio_accept: got load=%0d inst=%0d rdy=%b want 2 1 0", load_cnt, inst_cnt, Inst_Req_Ready);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({Read_data_Valid, Read_data, Inst_Req_Ready} !== {1'b1, 32'h11BB3344, 1'b0})
      $display("FAIL prio_data_first: got valid=%b data=%h rdy=%b want 1 11bb3344 0",
               Read_data_Valid, Read_data, Inst_Req_Ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Inst_Req_Ready, Read_data_Valid} !== 2'b10)
      $display("FAIL prio_inst_turn: got rdy=%b dvalid=%b want 1 0", Inst_Req_Ready, Read_data_Valid); else pass_cnt++;
    tick();
    Inst_Req_Valid = 1'b0;
    total_cnt++;
    if ({inst_cnt, mem_en, mem_addr} !== {32'd2, 1'b1, 16'd4})
      $display("FAIL prio_inst_issue: got cnt=%0d en=%b addr=%0d want 2 1 4", inst_cnt, mem_en, mem_addr);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({Inst_Valid, Instruction} !== {1'b1, 32'h00000013})
      $display("FAIL prio_inst_rsp: got valid=%b inst=%h want 1 00000013", Inst_Valid, Instruction); else pass_cnt++;
    tick();
    $display("test_priority done");
  endtask

  task automatic test_backpressure();
    Read_data_Ready = 1'b0;
    MemRead = 1'b1; Address = 32'h14;
    tick();
    MemRead = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({Read_data_Valid, Read_data} !== {1'b1, 32'hDEADBEEF})
        $display("FAIL bp_hold_%0d: got valid=%b data=%h want 1 deadbeef", i, Read_data_Valid, Read_data);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (Read_data_Valid !== 1'b1) $display("FAIL bp_still_valid: got %b want 1", Read_data_Valid); else pass_cnt++;
    Read_data_Ready = 1'b1;
    tick();
    total_cnt++;
    if ({Read_data_Valid, Mem_Req_Ready, Read_data, load_cnt} !== {1'b0, 1'b1, 32'hDEADBEEF, 32'd3})
      $display("FAIL bp_release: got valid=%b rdy=%b data=%h cnt=%0d want 0 1 deadbeef 3",
               Read_data_Valid, Mem_Req_Ready, Read_data, load_cnt);
    else pass_cnt++;
    $display("test_backpressure done");
  endtask

  task automatic test_rdlat3_wrap_reset();
    bit seen;
    MemRead_3 = 1'b1; Address_3 = 32'h40000010;
    tick();
    MemRead_3 = 1'b0;
    total_cnt++;
    if ({mem_en_3, mem_addr_3} !== {1'b1, 16'd4})
      $display("FAIL lat3_wrap_addr: got en=%b addr=%0d want 1 4", mem_en_3, mem_addr_3); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if (Read_data_Valid_3 !== 1'b0) $display("FAIL lat3_early: got %b want 0", Read_data_Valid_3); else pass_cnt++;
    tick();
    total_cnt++;
    if ({Read_data_Valid_3, Read_data_3} !== {1'b1, 32'hCAFEF00D})
      $display("FAIL lat3_rsp: got valid=%b data=%h want 1 cafef00d", Read_data_Valid_3, Read_data_3); else pass_cnt++;
    tick();
    MemRead_3 = 1'b1;
    tick();
    MemRead_3 = 1'b0;
    tick(); tick();
    #2;
    rst3 = 1'b1;
    #1;
    total_cnt++;
    if ({Inst_Req_Ready_3, Mem_Req_Ready_3, Inst_Valid_3, Read_data_Valid_3, mem_en_3, mem_wen_3, Instruction_3,
         Read_data_3, mem_addr_3, mem_wdata_3, inst_cnt_3, load_cnt_3, store_cnt_3} !== '0)
      $display("FAIL lat3_async_reset: outputs nonzero, data=%h load_cnt=%0d", Read_data_3, load_cnt_3);
    else pass_cnt++;
    tick(); tick();
    rst3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Read_data_Valid_3) seen = 1'b1;
    end
    total_cnt++;
    if ({seen, Mem_Req_Ready_3} !== 2'b01)
      $display("FAIL lat3_no_rsp: got seen=%b rdy=%b want 0 1", seen, Mem_Req_Ready_3); else pass_cnt++;
    $display("test_rdlat3_wrap_reset done");
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      sram1[i] = '0;
      sram3[i] = '0;
    end
    sram1[4] = 32'h00000013;
    sram1[5] = 32'hDEADBEEF;
    sram1[8] = 32'h11223344;
    sram3[4] = 32'hCAFEF00D;
    rd3_a = '0; rd3_b = '0; mem_rdata = '0; mem_rdata_3 = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b1; Address = '0; MemRead = 1'b0; MemWrite = 1'b0;
    Write_data = '0; Write_strb = '0; Read_data_Ready = 1'b1;
    PC_3 = '0; Inst_Req_Valid_3 = 1'b0; Inst_Ready_3 = 1'b1; Address_3 = '0; MemRead_3 = 1'b0;
    MemWrite_3 = 1'b0; Write_data_3 = '0; Write_strb_3 = '0; Read_data_Ready_3 = 1'b1;

    test_reset();
    test_inst_fetch();
    test_write_read();
    test_priority();
    test_backpressure();
    test_rdlat3_wrap_reset();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
